// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: per-stage stall/flush bundle,
// register address, forwarding selects and scheduler states.
package hazard_ctrl_pkg;

   typedef logic [4:0] creg_addr_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctrl_t;

   typedef struct packed {
      stage_ctrl_t fetch;
      stage_ctrl_t decode;
      stage_ctrl_t execute;
      stage_ctrl_t memory;
      stage_ctrl_t writeback;
   } hazard_data_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_M  = 2'd1,
      FWD_W  = 2'd2
   } fwd_sel_t;

   typedef enum logic {
      IDLE       = 1'b0,
      REDIR_PEND = 1'b1
   } hazard_state_t;

   // A producer only counts if it writes a real register that matches the source.
   function automatic logic reg_match(input logic we, input creg_addr_t rd, input creg_addr_t src);
      return we && (rd != '0) && (rd == src);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one D-stage source register; the M stage has
// the younger result and therefore wins over W.
module hazard_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  creg_addr_t src,
   input  creg_addr_t m_rd,
   input  logic       m_reg_write,
   input  creg_addr_t w_rd,
   input  logic       w_reg_write,
   output fwd_sel_t   sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_match(m_reg_write, m_rd, src))
         sel = FWD_M;
      else if (reg_match(w_reg_write, w_rd, src))
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage core: load-use/RAW interlocks, branch redirect
// sequencing against in-flight fetches, dmem freeze. HAZARD_FORWARD_EN enables bypassing.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | normal operation, redirects issued directly from E
// REDIR_PEND | taken branch seen while a fetch was outstanding; waiting
//            | for that fetch to return before loading pend_pc
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_req,
   input  logic             fetch_ok,
   input  logic             dmem_req,
   input  logic             dmem_ok,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic             d_use_rs,
   input  logic             d_use_rt,
   input  logic [4:0]       e_rd,
   input  logic             e_reg_write,
   input  logic             e_mem_to_reg,
   input  logic [4:0]       m_rd,
   input  logic             m_reg_write,
   input  logic [4:0]       w_rd,
   input  logic             w_reg_write,
   input  logic             br_valid,
   input  logic [31:0]      br_target,
   output hazard_data_t     hazard,
   output logic             pc_redir_valid,
   output logic [31:0]      pc_redir,
   output fwd_sel_t         fwd_a,
   output fwd_sel_t         fwd_b,
   output logic [CNT_W-1:0] stall_cycles
);

   hazard_state_t state, state_nxt;
   logic [31:0]   pend_pc;
   logic          pend_load;
   logic          mem_stall, fetch_wait, load_use, data_hazard;
   fwd_sel_t      sel_a, sel_b;

   assign mem_stall  = dmem_req && !dmem_ok;
   assign fetch_wait = fetch_req && !fetch_ok;
   assign load_use   = e_mem_to_reg &&
                       ((d_use_rs && reg_match(e_reg_write, e_rd, d_rs)) ||
                        (d_use_rt && reg_match(e_reg_write, e_rd, d_rt)));

   hazard_fwd_sel u_fwd_rs (
      .src         (d_rs),
      .m_rd        (m_rd),
      .m_reg_write (m_reg_write),
      .w_rd        (w_rd),
      .w_reg_write (w_reg_write),
      .sel         (sel_a)
   );

   hazard_fwd_sel u_fwd_rt (
      .src         (d_rt),
      .m_rd        (m_rd),
      .m_reg_write (m_reg_write),
      .w_rd        (w_rd),
      .w_reg_write (w_reg_write),
      .sel         (sel_b)
   );

`ifdef HAZARD_FORWARD_EN
   assign data_hazard = load_use;
   assign fwd_a       = reset ? FWD_RF : sel_a;
   assign fwd_b       = reset ? FWD_RF : sel_b;
`else
   // Without bypassing, any in-flight producer of a D source interlocks until it leaves W.
   logic raw_e, raw_mw;
   assign raw_e  = (d_use_rs && reg_match(e_reg_write, e_rd, d_rs)) ||
                   (d_use_rt && reg_match(e_reg_write, e_rd, d_rt));
   assign raw_mw = (d_use_rs && (sel_a != FWD_RF)) ||
                   (d_use_rt && (sel_b != FWD_RF));
   assign data_hazard = load_use || raw_e || raw_mw;
   assign fwd_a       = FWD_RF;
   assign fwd_b       = FWD_RF;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pend_pc      <= '0;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         if (pend_load)
            pend_pc <= br_target;
         if (hazard.fetch.stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt      = state;
      hazard         = '0;
      pc_redir_valid = 1'b0;
      pc_redir       = '0;
      pend_load      = 1'b0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               if (mem_stall) begin
                  hazard.fetch.stall   = 1'b1;
                  hazard.decode.stall  = 1'b1;
                  hazard.execute.stall = 1'b1;
                  hazard.memory.stall  = 1'b1;
               end else if (br_valid && !fetch_wait) begin
                  pc_redir_valid       = 1'b1;
                  pc_redir             = br_target;
                  hazard.fetch.flush   = 1'b1;
                  hazard.decode.flush  = 1'b1;
               end else if (br_valid) begin
                  pend_load            = 1'b1;
                  state_nxt            = REDIR_PEND;
                  hazard.fetch.flush   = 1'b1;
                  hazard.decode.flush  = 1'b1;
               end else if (data_hazard) begin
                  hazard.fetch.stall   = 1'b1;
                  hazard.decode.stall  = 1'b1;
                  hazard.execute.flush = 1'b1;
               end
               if (fetch_wait)
                  hazard.fetch.stall = 1'b1;
            end
            REDIR_PEND: begin
               // Whatever the outstanding fetch returns is wrong-path.
               hazard.fetch.flush = 1'b1;
               if (mem_stall) begin
                  hazard.fetch.stall   = 1'b1;
                  hazard.decode.stall  = 1'b1;
                  hazard.execute.stall = 1'b1;
                  hazard.memory.stall  = 1'b1;
               end
               if (fetch_ok) begin
                  pc_redir_valid = 1'b1;
                  pc_redir       = pend_pc;
                  state_nxt      = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, which
// are popped and compared mid-cycle. Expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int CNT_W  = 4;
   localparam int SC_MAX = 15;
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   // Bit order: F.stall F.flush D.stall D.flush E.stall E.flush M.stall M.flush W.stall W.flush
   localparam logic [9:0] HZ_NONE = 10'b00_00_00_00_00;
   localparam logic [9:0] HZ_LU   = 10'b10_10_01_00_00;
   localparam logic [9:0] HZ_MEM  = 10'b10_10_10_10_00;
   localparam logic [9:0] HZ_BR   = 10'b01_01_00_00_00;
   localparam logic [9:0] HZ_FW   = 10'b10_00_00_00_00;
   localparam logic [9:0] HZ_PEND = 10'b01_00_00_00_00;
   localparam logic [9:0] HZ_BRW  = 10'b11_01_00_00_00;

   logic             clk, reset;
   logic             fetch_req, fetch_ok, dmem_req, dmem_ok;
   logic [4:0]       d_rs, d_rt, e_rd, m_rd, w_rd;
   logic             d_use_rs, d_use_rt, e_reg_write, e_mem_to_reg, m_reg_write, w_reg_write;
   logic             br_valid;
   logic [31:0]      br_target;
   hazard_data_t     hazard;
   logic             pc_redir_valid;
   logic [31:0]      pc_redir;
   fwd_sel_t         fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cycles;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_req      (fetch_req),
      .fetch_ok       (fetch_ok),
      .dmem_req       (dmem_req),
      .dmem_ok        (dmem_ok),
      .d_rs           (d_rs),
      .d_rt           (d_rt),
      .d_use_rs       (d_use_rs),
      .d_use_rt       (d_use_rt),
      .e_rd           (e_rd),
      .e_reg_write    (e_reg_write),
      .e_mem_to_reg   (e_mem_to_reg),
      .m_rd           (m_rd),
      .m_reg_write    (m_reg_write),
      .w_rd           (w_rd),
      .w_reg_write    (w_reg_write),
      .br_valid       (br_valid),
      .br_target      (br_target),
      .hazard         (hazard),
      .pc_redir_valid (pc_redir_valid),
      .pc_redir       (pc_redir),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .stall_cycles   (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [9:0]  hz;
      logic        rv;
      logic [31:0] pc;
      fwd_sel_t    fa;
      fwd_sel_t    fb;
      int          sc;
      bit          sc_chk;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   sc_model = 0;
   bit   sc_known = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle_in();
      fetch_req = 0; fetch_ok = 0; dmem_req = 0; dmem_ok = 0;
      d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
      e_rd = 0; e_reg_write = 0; e_mem_to_reg = 0;
      m_rd = 0; m_reg_write = 0; w_rd = 0; w_reg_write = 0;
      br_valid = 0; br_target = 0;
   endtask

   task automatic load_in_e(input logic [4:0] rd);
      e_rd = rd; e_reg_write = 1; e_mem_to_reg = 1;
   endtask

   task automatic step(input string tag, input logic [9:0] hz, input logic rv,
                       input logic [31:0] pc, input fwd_sel_t fa, input fwd_sel_t fb);
      exp_t e;
      e.tag = tag; e.hz = hz; e.rv = rv; e.pc = pc; e.fa = fa; e.fb = fb;
      e.sc = sc_model; e.sc_chk = sc_known;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, ".hazard"}, 32'(hazard), 32'(e.hz));
         check({e.tag, ".redir_valid"}, 32'(pc_redir_valid), 32'(e.rv));
         if (e.rv)
            check({e.tag, ".pc_redir"}, pc_redir, e.pc);
         check({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
         check({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
         if (e.sc_chk)
            check({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
      end
      if (reset) begin
         sc_model = 0;
         sc_known = 1'b1;
      end else if (hz[9] && sc_model < SC_MAX) begin
         sc_model++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_in();
      reset = 1;
      br_valid = 1; br_target = 32'h0000_1000; dmem_req = 1; fetch_req = 1;
      step("rst0", HZ_NONE, 0, 0, FWD_RF, FWD_RF);
      m_rd = 4; m_reg_write = 1; d_rs = 4; d_use_rs = 1;
      step("rst1", HZ_NONE, 0, 0, FWD_RF, FWD_RF);
      reset = 0;
      idle_in();
      step("idle", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      // lw $8 in E, add $9,$8,$1 in D
      load_in_e(8); d_rs = 8; d_use_rs = 1; d_rt = 1; d_use_rt = 1;
      step("lu", HZ_LU, 0, 0, FWD_RF, FWD_RF);
      e_rd = 0; e_reg_write = 0; e_mem_to_reg = 0; m_rd = 8; m_reg_write = 1;
      step("lu_m", FWD_EN ? HZ_NONE : HZ_LU, 0, 0, FWD_EN ? FWD_M : FWD_RF, FWD_RF);
      m_rd = 0; m_reg_write = 0; w_rd = 8; w_reg_write = 1;
      step("lu_w", FWD_EN ? HZ_NONE : HZ_LU, 0, 0, FWD_EN ? FWD_W : FWD_RF, FWD_RF);
      idle_in();
      step("lu_done", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      load_in_e(8); d_rs = 8; d_rt = 8;
      step("lu_nouse", HZ_NONE, 0, 0, FWD_RF, FWD_RF);
      idle_in(); load_in_e(9); d_rs = 2; d_use_rs = 1; d_rt = 9; d_use_rt = 1;
      step("lu_rt", HZ_LU, 0, 0, FWD_RF, FWD_RF);
      idle_in(); load_in_e(0); d_rs = 0; d_use_rs = 1;
      step("lu_r0", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      // taken branch, no fetch outstanding, load-use on wrong-path D suppressed
      idle_in(); br_valid = 1; br_target = 32'h0040_0040;
      load_in_e(8); d_rs = 8; d_use_rs = 1;
      step("br_idle", HZ_BR, 1, 32'h0040_0040, FWD_RF, FWD_RF);
      idle_in(); fetch_req = 1;
      step("br_stay_idle", HZ_FW, 0, 0, FWD_RF, FWD_RF);
      fetch_ok = 1;
      step("fetch_ok_idle", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      // taken branch while fetch outstanding; fetch returns 3 cycles later
      idle_in(); fetch_req = 1; br_valid = 1; br_target = 32'h0000_0080;
      step("brp0", HZ_BRW, 0, 0, FWD_RF, FWD_RF);
      br_valid = 0;
      step("brp1", HZ_PEND, 0, 0, FWD_RF, FWD_RF);
      br_valid = 1; br_target = 32'hdead_0000;
      step("brp2", HZ_PEND, 0, 0, FWD_RF, FWD_RF);
      br_valid = 0; fetch_ok = 1;
      step("brp3", HZ_PEND, 1, 32'h0000_0080, FWD_RF, FWD_RF);
      idle_in();
      step("brp4", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      // dmem wait overrides both branch and load-use
      dmem_req = 1; br_valid = 1; br_target = 32'h1234_5678;
      load_in_e(8); d_rs = 8; d_use_rs = 1;
      for (int i = 0; i < 4; i++)
         step("mem_wait", HZ_MEM, 0, 0, FWD_RF, FWD_RF);
      dmem_ok = 1;
      step("mem_ok", HZ_BR, 1, 32'h1234_5678, FWD_RF, FWD_RF);

      // forwarding priority and $0
      idle_in(); m_rd = 5; m_reg_write = 1; w_rd = 5; w_reg_write = 1;
      d_rs = 5; d_use_rs = 1; d_rt = 0; d_use_rt = 1;
      step("fwd_mw", FWD_EN ? HZ_NONE : HZ_LU, 0, 0, FWD_EN ? FWD_M : FWD_RF, FWD_RF);
      m_rd = 6; d_rs = 6; w_rd = 7; d_rt = 7;
      step("fwd_split", FWD_EN ? HZ_NONE : HZ_LU, 0, 0,
           FWD_EN ? FWD_M : FWD_RF, FWD_EN ? FWD_W : FWD_RF);

      // ALU producer add $3 walks E -> M -> W -> retired
      idle_in(); d_rs = 3; d_use_rs = 1; e_rd = 3; e_reg_write = 1;
      step("raw_e", FWD_EN ? HZ_NONE : HZ_LU, 0, 0, FWD_RF, FWD_RF);
      e_rd = 0; e_reg_write = 0; m_rd = 3; m_reg_write = 1;
      step("raw_m", FWD_EN ? HZ_NONE : HZ_LU, 0, 0, FWD_EN ? FWD_M : FWD_RF, FWD_RF);
      m_rd = 0; m_reg_write = 0; w_rd = 3; w_reg_write = 1;
      step("raw_w", FWD_EN ? HZ_NONE : HZ_LU, 0, 0, FWD_EN ? FWD_W : FWD_RF, FWD_RF);
      w_rd = 0; w_reg_write = 0;
      step("raw_done", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      // reset while a redirect is pending drops it
      idle_in(); fetch_req = 1; br_valid = 1; br_target = 32'h0000_0200;
      step("rp_enter", HZ_BRW, 0, 0, FWD_RF, FWD_RF);
      br_valid = 0; reset = 1;
      step("rp_reset", HZ_NONE, 0, 0, FWD_RF, FWD_RF);
      reset = 0; fetch_ok = 1;
      step("rp_no_redir", HZ_NONE, 0, 0, FWD_RF, FWD_RF);
      fetch_ok = 0;
      step("rp_idle", HZ_FW, 0, 0, FWD_RF, FWD_RF);

      // long fetch wait drives the counter into saturation
      for (int i = 0; i < 20; i++)
         step("sat", HZ_FW, 0, 0, FWD_RF, FWD_RF);
      idle_in();
      step("sat_hold", HZ_NONE, 0, 0, FWD_RF, FWD_RF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline scheduler for the 5-stage core (F/D/E/M/W).
- Detects load-use and RAW hazards.
- Sequences branch/jump redirects against in-flight instruction fetches, and freezes the pipe during data-memory waits.
- Drives the per-stage hazard_data_t stall/flush bundle, PC redirect and forwarding selects; sits beside the pipeline registers in the core top.

Parameters:
- CNT_W, 32, width of saturating stall-cycle counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  F has an ibus request outstanding
- fetch_ok  in  1  ibus data returned this cycle
- dmem_req  in  1  M has a dbus request outstanding
- dmem_ok  in  1  dbus data returned this cycle
- d_rs, d_rt  in  5 each  D-stage source registers
- d_use_rs, d_use_rt  in  1 each  D actually reads rs/rt
- e_rd  in  5  E-stage destination
- e_reg_write, e_mem_to_reg  in  1 each  E writes reg / E is a load
- m_rd  in  5  M-stage destination
- m_reg_write  in  1  M writes reg
- w_rd  in  5  W-stage destination
- w_reg_write  in  1  W writes reg
- br_valid  in  1  E resolved a taken branch/jump
- br_target  in  32  redirect target
- hazard  out  hazard_data_t  stall = hold X->next reg; flush = load bubble into X->next reg
- pc_redir_valid  out  1  one-cycle PC load strobe
- pc_redir  out  32  PC load value
- fwd_a, fwd_b  out  fwd_sel_t(2)  operand source for D->E rs/rt
- stall_cycles  out  CNT_W  cycles with hazard.fetch.stall=1, saturating

Behaviour:
- Reset (sync): state=IDLE, pend_pc=0, stall_cycles=0.
- Outputs during reset cycle: hazard all 0, pc_redir_valid=0, fwd=FWD_RF.
- States: IDLE, REDIR_PEND.
- Hazard terms:
  - mem_stall = dmem_req & ~dmem_ok.
  - load_use = e_mem_to_reg & e_reg_write & e_rd!=0 & ((d_use_rs & d_rs==e_rd) | (d_use_rt & d_rt==e_rd)).
- Priority, highest first:
  1. mem_stall: stall F, D, E, M; no flush; br_valid ignored (E is frozen, so it stays asserted).
  2. br_valid in IDLE with no fetch outstanding or fetch_ok same cycle:
     - pc_redir_valid=1 and pc_redir=br_target, combinational, same cycle.
     - flush F and D.
     - load_use is suppressed because D is wrong-path.
  3. br_valid in IDLE with fetch_req & ~fetch_ok:
     - latch pend_pc=br_target, go to REDIR_PEND.
     - flush F and D this cycle.
  4. load_use: stall F and D, flush E (one bubble). Latency is exactly 1 cycle per load-use.
- REDIR_PEND:
  - flush F every cycle, so the wrong-path fetch is discarded.
  - On fetch_ok: pc_redir_valid=1, pc_redir=pend_pc, return to IDLE.
  - br_valid is ignored in this state; E holds a bubble.
  - mem_stall still overrides, adding stall F..M; flush F is kept.
- Fetch wait, independent of the above: fetch_req & ~fetch_ok in IDLE stalls F only.
- Forwarding per operand:
  - FWD_M if m_reg_write & m_rd!=0 & m_rd==src.
  - else FWD_W if the same test matches W.
  - else FWD_RF.
  - M beats W.
- stall_cycles: +1 per cycle with hazard.fetch.stall=1; holds at 2^CNT_W-1.
- Reset mid-REDIR_PEND: pend_pc is discarded; no redirect is issued afterwards.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_a and fwd_b tied to FWD_RF.
  - RAW against E, M or W (reg_write, rd!=0, match) is treated like load_use: stall F/D, flush E, until the producer has retired past W.
  - Priority is unchanged.

Decomposition:
- pipes package additions:
  - enum fwd_sel_t {FWD_RF=0, FWD_M=1, FWD_W=2}
  - enum hazard_state_t {IDLE, REDIR_PEND}
- Reuse hazard_data_t and creg_addr_t.
- One sub-module: hazard_fwd_sel (combinational, src addr + M/W info -> fwd_sel_t), instantiated for rs and rt.

Test Plan:
- Load-use: E lw $8, D add $9,$8,$1 -> 1 cycle stall F/D + flush E; next cycle fwd_a=FWD_M; stall_cycles=1.
- Branch, fetch idle: br_valid=1, br_target=0x00400040 -> same-cycle pc_redir_valid=1, pc_redir=0x00400040, flush F/D, state stays IDLE.
- Branch with fetch outstanding: fetch_ok arrives 3 cycles after br_valid (target 0x80) -> REDIR_PEND, flush F on each of those cycles, pc_redir=0x80 pulses exactly on the fetch_ok cycle.
- dmem wait 4 cycles with br_valid and load_use both asserted -> F..M stalled 4 cycles, no redirect; redirect fires on the dmem_ok cycle.
- Forward priority: M and W both write $5, D reads $5 as rs and $0 as rt -> fwd_a=FWD_M, fwd_b=FWD_RF.
- Reset asserted in REDIR_PEND, then fetch_ok -> no pc_redir_valid, stall_cycles=0; without HAZARD_FORWARD_EN, add $3 in M feeding D -> stall until retired, fwd always FWD_RF.
